// File: rtl/go_ctrl_pkg.sv
// Shared types and constants for the goboard Lite controller: register map,
// row-queue entry layout and sequencer state encodings.
package go_ctrl_pkg;

    localparam int REG_CTRL   = 38;
    localparam int REG_STATUS = 39;
    localparam int TEXT_BASE  = 64;

    localparam int ST_BUSY_BOARD = 0;
    localparam int ST_BUSY_TEXT  = 1;
    localparam int ST_FIFO_FULL  = 2;
    localparam int ST_ROW_OVF    = 3;
    localparam int ST_TEXT_DROP  = 4;
    localparam int ST_DONE       = 5;

    typedef struct packed {
        logic [4:0]  addr;
        logic [37:0] pieces;
    } row_entry_t;

    typedef enum logic [1:0] {BRD_IDLE, BRD_WAIT, BRD_SWEEP} board_state_t;
    typedef enum logic {TXT_IDLE, TXT_SWEEP} text_state_t;

endpackage

// File: rtl/go_lite_ctrl_if.sv
// Xillybus Lite bus bundle, plus the row-commit queue handshake between the
// register front-end and its FIFO.
interface go_lite_ctrl_if;
    logic        wren;
    logic [3:0]  wstrb;
    logic        rden;
    logic [11:0] addr;
    logic [31:0] wr_data;
    logic [31:0] rd_data;
    logic        irq;

    modport master (output wren, wstrb, rden, addr, wr_data, input rd_data, irq);
    modport slave  (input wren, wstrb, rden, addr, wr_data, output rd_data, irq);
endinterface

interface go_row_q_if;
    import go_ctrl_pkg::*;

    logic       push;
    row_entry_t din;
    logic       full;
    logic       pop;
    row_entry_t dout;
    logic       empty;

    modport master (output push, din, pop, input full, dout, empty);
    modport slave  (input push, din, pop, output full, dout, empty);
endinterface

// File: rtl/go_row_fifo.sv
// Show-ahead synchronous FIFO holding pending goboard row commits; the head
// entry is visible on dout while the queue is non-empty.
module go_row_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    go_row_q_if.slave  q
);
    import go_ctrl_pkg::*;

    localparam int AW = $clog2(DEPTH);

    row_entry_t  mem_q [DEPTH];
    logic [AW:0] wr_ptr_q;
    logic [AW:0] rd_ptr_q;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign q.empty = (wr_ptr_q == rd_ptr_q);
    assign q.full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign q.dout  = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (q.push) begin
                mem_q[wr_ptr_q[AW-1:0]] <= q.din;
                wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            end
            if (q.pop) begin
                rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/go_lite_ctrl.sv
// Lite register front-end for the goboard display: row shadows and commit
// queue, board/text clear sequencers, sticky status and level interrupt.
module go_lite_ctrl #(
    parameter int         FIFO_DEPTH = 4,
    parameter int         ROWS       = 19,
    parameter int         TEXT_BASE  = go_ctrl_pkg::TEXT_BASE,
    parameter int         TEXT_DEPTH = 512,
    parameter logic [7:0] BLANK_CHAR = 8'h20
) (
    input  logic        user_clk,
    input  logic        rst_n_i,
    input  logic        user_wren,
    input  logic [3:0]  user_wstrb,
    input  logic        user_rden,
    input  logic [11:0] user_addr,
    input  logic [31:0] user_wr_data,
    output logic [31:0] user_rd_data,
    output logic        user_irq,
    output logic [4:0]  addr_o,
    output logic [37:0] pieces_o,
    output logic        wEnable_o,
    output logic        wea_o,
    output logic [7:0]  ascii_o,
    output logic [8:0]  write_ram_addr_o
);
    import go_ctrl_pkg::*;

    localparam logic [9:0] HI_LO    = 10'(ROWS);
    localparam logic [9:0] HI_END   = 10'(2 * ROWS);
    localparam logic [9:0] TX_LO    = 10'(TEXT_BASE);
    localparam logic [9:0] TX_END   = 10'(TEXT_BASE + TEXT_DEPTH);
    localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);
    localparam logic [8:0] LAST_TXT = 9'(TEXT_DEPTH - 1);

    logic [31:0]  shadow_l_q [ROWS];
    logic [5:0]   shadow_h_q [ROWS];
    board_state_t brd_q;
    text_state_t  txt_q;
    logic [4:0]   brd_cnt_q;
    logic [8:0]   txt_cnt_q;
    logic         irq_en_q, row_ovf_q, text_drop_q, done_q, irq_q;
    logic         irq_en_d, row_ovf_d, text_drop_d, done_d;
    logic [31:0]  rd_data_q, rd_d, status_w;
    logic [4:0]   addr_q;
    logic [37:0]  pieces_q;
    logic         wen_q, wea_q;
    logic [7:0]   ascii_q;
    logic [8:0]   ram_addr_q;

    logic [9:0]   w;
    logic [4:0]   row_idx;
    logic         full_wr, wr_lo, wr_hi, wr_ctrl, wr_stat, wr_text;
    logic         brd_end, txt_end;
    logic         unused_addr_bits;

    go_row_q_if rq ();

    go_row_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (user_clk),
        .rst_n (rst_n_i),
        .q     (rq)
    );

    assign w                = user_addr[11:2];
    assign unused_addr_bits = &{1'b0, user_addr[1:0]};

    always_comb begin
        full_wr = user_wren && (user_wstrb == 4'hF);
        wr_lo   = full_wr && (w < HI_LO);
        wr_hi   = full_wr && (w >= HI_LO) && (w < HI_END);
        wr_ctrl = full_wr && (w == 10'(REG_CTRL));
        wr_stat = full_wr && (w == 10'(REG_STATUS));
        wr_text = user_wren && user_wstrb[0] && (w >= TX_LO) && (w < TX_END);
        row_idx = (w < HI_LO) ? w[4:0] : 5'(w - HI_LO);

        // Drain keeps running while a clear waits for the queue to empty.
        rq.pop  = !rq.empty && (brd_q != BRD_SWEEP);
        rq.push = wr_lo && (!rq.full || rq.pop);
        rq.din  = '{addr: row_idx, pieces: {shadow_h_q[row_idx], user_wr_data}};

        brd_end = (brd_q == BRD_SWEEP) && (brd_cnt_q == LAST_ROW);
        txt_end = (txt_q == TXT_SWEEP) && (txt_cnt_q == LAST_TXT);

        // Set conditions take priority over a write-one-to-clear on the same edge.
        done_d      = brd_end || txt_end ||
                      (done_q && !(wr_stat && user_wr_data[ST_DONE]));
        row_ovf_d   = (wr_lo && !rq.push) ||
                      (row_ovf_q && !(wr_stat && user_wr_data[ST_ROW_OVF]));
        text_drop_d = (wr_text && (txt_q == TXT_SWEEP)) ||
                      (text_drop_q && !(wr_stat && user_wr_data[ST_TEXT_DROP]));
        irq_en_d    = wr_ctrl ? user_wr_data[2] : irq_en_q;

        status_w                = '0;
        status_w[ST_BUSY_BOARD] = (brd_q != BRD_IDLE);
        status_w[ST_BUSY_TEXT]  = (txt_q == TXT_SWEEP);
        status_w[ST_FIFO_FULL]  = rq.full;
        status_w[ST_ROW_OVF]    = row_ovf_q;
        status_w[ST_TEXT_DROP]  = text_drop_q;
        status_w[ST_DONE]       = done_q;

        rd_d = '0;
        if (w < HI_LO)                    rd_d = shadow_l_q[row_idx];
        else if (w < HI_END)              rd_d = {26'b0, shadow_h_q[row_idx]};
        else if (w == 10'(REG_CTRL))      rd_d = {29'b0, irq_en_q, 2'b0};
        else if (w == 10'(REG_STATUS))    rd_d = status_w;
    end

    always_ff @(posedge user_clk) begin
        if (!rst_n_i) begin
            for (int r = 0; r < ROWS; r++) begin
                shadow_l_q[r] <= '0;
                shadow_h_q[r] <= '0;
            end
            brd_q       <= BRD_IDLE;
            txt_q       <= TXT_IDLE;
            brd_cnt_q   <= '0;
            txt_cnt_q   <= '0;
            irq_en_q    <= 1'b0;
            row_ovf_q   <= 1'b0;
            text_drop_q <= 1'b0;
            done_q      <= 1'b0;
            irq_q       <= 1'b0;
            rd_data_q   <= '0;
            addr_q      <= '0;
            pieces_q    <= '0;
            wen_q       <= 1'b0;
            wea_q       <= 1'b0;
            ascii_q     <= '0;
            ram_addr_q  <= '0;
        end else begin
            wen_q       <= 1'b0;
            wea_q       <= 1'b0;
            irq_en_q    <= irq_en_d;
            row_ovf_q   <= row_ovf_d;
            text_drop_q <= text_drop_d;
            done_q      <= done_d;
            irq_q       <= irq_en_d & done_d;
            if (user_rden) rd_data_q <= rd_d;

            if (rq.pop) begin
                addr_q   <= rq.dout.addr;
                pieces_q <= rq.dout.pieces;
                wen_q    <= 1'b1;
            end

            case (brd_q)
                BRD_IDLE: if (wr_ctrl && user_wr_data[0]) brd_q <= BRD_WAIT;
                BRD_WAIT: if (rq.empty) begin
                    brd_q     <= BRD_SWEEP;
                    brd_cnt_q <= '0;
                    for (int r = 0; r < ROWS; r++) begin
                        shadow_l_q[r] <= '0;
                        shadow_h_q[r] <= '0;
                    end
                end
                BRD_SWEEP: begin
                    addr_q    <= brd_cnt_q;
                    pieces_q  <= '0;
                    wen_q     <= 1'b1;
                    brd_cnt_q <= brd_cnt_q + 5'd1;
                    if (brd_end) brd_q <= BRD_IDLE;
                end
                default: brd_q <= BRD_IDLE;
            endcase

            if (wr_lo) shadow_l_q[row_idx] <= user_wr_data;
            if (wr_hi) shadow_h_q[row_idx] <= user_wr_data[5:0];

            case (txt_q)
                TXT_IDLE: begin
                    if (wr_ctrl && user_wr_data[1]) begin
                        txt_q     <= TXT_SWEEP;
                        txt_cnt_q <= '0;
                    end
                    if (wr_text) begin
                        wea_q      <= 1'b1;
                        ascii_q    <= user_wr_data[7:0];
                        ram_addr_q <= 9'(w - TX_LO);
                    end
                end
                TXT_SWEEP: begin
                    wea_q      <= 1'b1;
                    ascii_q    <= BLANK_CHAR;
                    ram_addr_q <= txt_cnt_q;
                    txt_cnt_q  <= txt_cnt_q + 9'd1;
                    if (txt_end) txt_q <= TXT_IDLE;
                end
            endcase
        end
    end

    assign user_rd_data     = rd_data_q;
    assign user_irq         = irq_q;
    assign addr_o           = addr_q;
    assign pieces_o         = pieces_q;
    assign wEnable_o        = wen_q;
    assign wea_o            = wea_q;
    assign ascii_o          = ascii_q;
    assign write_ram_addr_o = ram_addr_q;

endmodule

// File: tb/tb_go_lite_ctrl.sv
// Self-checking bench for go_lite_ctrl: register table, random traffic against
// a transaction-level model, and directed clear/reset sequences.
module tb_go_lite_ctrl;

    typedef struct { logic [4:0] a; logic [37:0] p; int cyc; } row_ev_t;
    typedef struct { logic [8:0] a; logic [7:0] c; int cyc; } txt_ev_t;
    typedef struct { int word; logic [3:0] strb; logic [31:0] d; int rword; logic [31:0] exp; } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  addr_o;
    logic [37:0] pieces_o;
    logic        wEnable_o, wea_o;
    logic [7:0]  ascii_o;
    logic [8:0]  ram_addr;

    go_lite_ctrl_if bus ();

    go_lite_ctrl dut (
        .user_clk         (clk),
        .rst_n_i          (rst_n),
        .user_wren        (bus.wren),
        .user_wstrb       (bus.wstrb),
        .user_rden        (bus.rden),
        .user_addr        (bus.addr),
        .user_wr_data     (bus.wr_data),
        .user_rd_data     (bus.rd_data),
        .user_irq         (bus.irq),
        .addr_o           (addr_o),
        .pieces_o         (pieces_o),
        .wEnable_o        (wEnable_o),
        .wea_o            (wea_o),
        .ascii_o          (ascii_o),
        .write_ram_addr_o (ram_addr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int checks = 0;
    int failures = 0;
    int last_wr_cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    row_ev_t got_rows[$], exp_rows[$];
    txt_ev_t got_txt[$], exp_txt[$];

    always @(negedge clk) begin
        if (wEnable_o) got_rows.push_back('{addr_o, pieces_o, cyc});
        if (wea_o) got_txt.push_back('{ram_addr, ascii_o, cyc});
    end

    // Transaction-level model: register contents and expected port traffic.
    logic [31:0] sh_l [19];
    logic [5:0]  sh_h [19];
    logic        irq_en_m;

    task automatic model_reset();
        for (int r = 0; r < 19; r++) begin sh_l[r] = '0; sh_h[r] = '0; end
        irq_en_m = 1'b0;
    endtask

    function automatic logic [31:0] model_rd(input int word);
        if (word < 19) return sh_l[word];
        if (word < 38) return {26'b0, sh_h[word-19]};
        if (word == 38) return {29'b0, irq_en_m, 2'b0};
        return 32'h0;
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic bus_write(input int word, input logic [3:0] strb, input logic [31:0] d);
        bus.wren = 1'b1; bus.wstrb = strb; bus.addr = 12'(word * 4); bus.wr_data = d;
        last_wr_cyc = cyc;
        @(posedge clk); #1;
        bus.wren = 1'b0;
    endtask

    task automatic bus_read(input int word, output logic [31:0] d);
        bus.rden = 1'b1; bus.addr = 12'(word * 4);
        @(posedge clk); #1;
        bus.rden = 1'b0;
        d = bus.rd_data;
    endtask

    task automatic model_write(input int word, input logic [3:0] strb, input logic [31:0] d);
        bus_write(word, strb, d);
        if (strb == 4'hF && word < 19) begin
            exp_rows.push_back('{5'(word), {sh_h[word], d}, 0});
            sh_l[word] = d;
        end else if (strb == 4'hF && word < 38) begin
            sh_h[word-19] = d[5:0];
        end else if (strb == 4'hF && word == 38) begin
            irq_en_m = d[2];
        end
        if (strb[0] && word >= 64 && word < 576)
            exp_txt.push_back('{9'(word - 64), d[7:0], 0});
    endtask

    task automatic check_rows(input string tag);
        row_ev_t g, e;
        repeat (6) @(posedge clk); #1;
        check({tag, "_row_count"}, got_rows.size(), exp_rows.size());
        while (exp_rows.size() > 0 && got_rows.size() > 0) begin
            g = got_rows.pop_front();
            e = exp_rows.pop_front();
            check({tag, "_row_addr"}, g.a, e.a);
            check({tag, "_row_pieces"}, g.p, e.p);
        end
        exp_rows.delete(); got_rows.delete();
    endtask

    task automatic check_txt(input string tag);
        txt_ev_t g, e;
        repeat (3) @(posedge clk); #1;
        check({tag, "_txt_count"}, got_txt.size(), exp_txt.size());
        while (exp_txt.size() > 0 && got_txt.size() > 0) begin
            g = got_txt.pop_front();
            e = exp_txt.pop_front();
            check({tag, "_txt_addr"}, g.a, e.a);
            check({tag, "_txt_char"}, g.c, e.c);
        end
        exp_txt.delete(); got_txt.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    vec_t        vt [10];
    logic [31:0] rd;
    int          t0, bad, word;
    bit          found;

    initial begin
        vt[0] = '{22, 4'hF, 32'h0000_002A, 22, 32'h0000_002A};
        vt[1] = '{22, 4'h7, 32'h0000_00FF, 22, 32'h0000_002A};
        vt[2] = '{20, 4'hF, 32'hFFFF_FFFF, 20, 32'h0000_003F};
        vt[3] = '{18, 4'hF, 32'hDEAD_BEEF, 18, 32'hDEAD_BEEF};
        vt[4] = '{38, 4'hF, 32'h0000_0004, 38, 32'h0000_0004};
        vt[5] = '{40, 4'hF, 32'h0000_1234, 40, 32'h0000_0000};
        vt[6] = '{0,  4'h1, 32'hCAFE_0000, 0,  32'h0000_0000};
        vt[7] = '{38, 4'h3, 32'h0000_0000, 38, 32'h0000_0004};
        vt[8] = '{38, 4'hF, 32'h0000_0000, 39, 32'h0000_0000};
        vt[9] = '{37, 4'hF, 32'h0000_0015, 18, 32'hDEAD_BEEF};

        bus.wren = 1'b0; bus.rden = 1'b0; bus.wstrb = '0; bus.addr = '0; bus.wr_data = '0;
        rst_n = 1'b0;
        model_reset();
        repeat (3) @(posedge clk); #1;
        check("rst_wEnable", wEnable_o, 0);
        check("rst_wea", wea_o, 0);
        check("rst_irq", bus.irq, 0);
        check("rst_rd_data", bus.rd_data, 0);
        check("rst_pieces", {addr_o, pieces_o, ascii_o, ram_addr}, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Row commit latency and readback
        model_write(22, 4'hF, 32'h2A);
        model_write(3, 4'hF, 32'h1234_5678);
        t0 = last_wr_cyc;
        repeat (4) @(posedge clk); #1;
        check("t1_one_pulse", got_rows.size(), 1);
        if (got_rows.size() > 0) begin
            check("t1_latency", got_rows[0].cyc - t0, 2);
            check("t1_addr", got_rows[0].a, 3);
            check("t1_pieces", got_rows[0].p, 38'h2A_1234_5678);
        end
        check_rows("t1");
        bus_read(3, rd);  check("t1_rd_lo3", rd, 32'h1234_5678);
        bus_read(22, rd); check("t1_rd_hi22", rd, 32'h2A);

        for (int i = 0; i < 10; i++) begin
            model_write(vt[i].word, vt[i].strb, vt[i].d);
            bus_read(vt[i].rword, rd);
            check($sformatf("tbl%0d_rd", i), rd, vt[i].exp);
        end
        check_rows("tbl");

        // Back-to-back row writes drain at one row per cycle without overflow
        for (int r = 0; r < 6; r++) model_write(r, 4'hF, 32'hA000_0000 + r);
        check_rows("t2");
        bus_read(39, rd); check("t2_status", rd, 32'h0);

        for (int i = 0; i < 150; i++) begin
            case ($urandom_range(0, 4))
                0: model_write($urandom_range(0, 18), ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF, $urandom);
                1: model_write($urandom_range(19, 37), 4'hF, $urandom);
                2: model_write($urandom_range(64, 575), 4'($urandom), $urandom);
                3: model_write(($urandom_range(0, 1) == 0) ? $urandom_range(40, 63) : $urandom_range(576, 1023), 4'hF, $urandom);
                default: begin
                    word = $urandom_range(0, 39);
                    bus_read(word, rd);
                    check($sformatf("rand_rd_w%0d", word), rd, model_rd(word));
                end
            endcase
        end
        check_rows("rand");
        check_txt("rand");

        // Board clear: queued row lands first, writes during the sweep queue up
        model_write(7, 4'hF, 32'h1);
        bus_write(38, 4'hF, 32'h1);
        irq_en_m = 1'b0;
        for (int r = 0; r < 19; r++) begin
            sh_l[r] = '0; sh_h[r] = '0;
            exp_rows.push_back('{5'(r), 38'h0, 0});
        end
        repeat (3) @(posedge clk); #1;
        bus_write(2, 4'hF, 32'hBEEF);
        sh_l[2] = 32'hBEEF;
        exp_rows.push_back('{5'd2, 38'hBEEF, 0});
        for (int k = 0; k < 5; k++) begin
            bus_write(10 + k, 4'hF, 32'h100 + k);
            sh_l[10+k] = 32'h100 + k;
            if (k < 3) exp_rows.push_back('{5'(10 + k), 38'(32'h100 + k), 0});
        end
        bus_read(39, rd); check("t3_status_busy", rd, 32'hD);
        repeat (14) @(posedge clk); #1;
        if (got_rows.size() >= 20) check("t3_sweep_contig", got_rows[19].cyc - got_rows[1].cyc, 18);
        else check("t3_sweep_len", got_rows.size(), 20);
        check_rows("t3");
        bus_read(39, rd); check("t3_status_done", rd, 32'h28);
        check("t3_irq_masked", bus.irq, 0);
        bus_read(7, rd);  check("t3_rd_cleared7", rd, 32'h0);
        bus_read(13, rd); check("t3_rd_dropped13", rd, 32'h103);
        bus_write(39, 4'hF, 32'h38);
        bus_read(39, rd); check("t3_status_w1c", rd, 32'h0);

        // Single text write
        model_write(64, 4'h1, 32'h41);
        t0 = last_wr_cyc;
        repeat (2) @(posedge clk); #1;
        if (got_txt.size() > 0) check("t4_latency", got_txt[0].cyc - t0, 1);
        else check("t4_present", got_txt.size(), 1);
        check_txt("t4");

        // Text clear with interrupt enabled
        bus_write(38, 4'hF, 32'h6);
        irq_en_m = 1'b1;
        repeat (50) @(posedge clk); #1;
        bus_write(100, 4'hF, 32'h55);
        repeat (470) @(posedge clk); #1;
        check("t5_txt_count", got_txt.size(), 512);
        bad = 0;
        for (int i = 0; i < got_txt.size(); i++)
            if (got_txt[i].a != 9'(i) || got_txt[i].c != 8'h20 || got_txt[i].cyc != got_txt[0].cyc + i) bad++;
        check("t5_txt_bad_entries", bad, 0);
        got_txt.delete();
        check("t5_irq", bus.irq, 1);
        bus_read(39, rd); check("t5_status", rd, 32'h30);
        bus_write(39, 4'hF, 32'h30);
        repeat (2) @(posedge clk); #1;
        check("t5_irq_cleared", bus.irq, 0);
        bus_read(38, rd); check("t5_ctrl_rd", rd, model_rd(38));

        // Reset in the middle of a board sweep
        bus_write(38, 4'hF, 32'h1);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(posedge clk); #1;
            if (wEnable_o && addr_o == 5'd9) found = 1'b1;
        end
        check("t6_reached_row9", found, 1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("t6_wEnable_rst", wEnable_o, 0);
        check("t6_addr_rst", addr_o, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
        got_rows.delete(); exp_rows.delete();
        bus_read(39, rd); check("t6_status_rst", rd, 32'h0);
        bus_write(38, 4'hF, 32'h1);
        for (int r = 0; r < 19; r++) exp_rows.push_back('{5'(r), 38'h0, 0});
        repeat (24) @(posedge clk); #1;
        if (got_rows.size() >= 19) check("t6_sweep_contig", got_rows[18].cyc - got_rows[0].cyc, 18);
        else check("t6_sweep_len", got_rows.size(), 19);
        check_rows("t6");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
